// File: rtl/wallace_mac.sv
// wallace_mac: pipelined 32x32 unsigned multiply-accumulate over valid/ready (optional WALLACE_MAC_SATURATE_EN)
module wallace (
    output logic [63:0] product,
    input  logic [31:0] a,
    input  logic [31:0] b
);
    function automatic int rows_at(input int l);
        int n;
        n = 32;
        for (int i = 0; i < l; i++) n = n - n / 3;
        return n;
    endfunction
    logic [63:0] r [32];
    logic [63:0] t [32];
    int n, g;
    // Partial products reduced by 3:2 carry-save layers until two rows remain
    always_comb begin
        n = 0;
        g = 0;
        for (int i = 0; i < 32; i++) r[i] = b[i] ? ({32'b0, a} << i) : 64'b0;
        t = r;
        for (int l = 0; l < 8; l++) begin
            n = rows_at(l);
            g = n / 3;
            t = r;
            for (int j = 0; j < 10; j++) begin
                if (j < g) begin
                    t[2*j]   = r[3*j] ^ r[3*j+1] ^ r[3*j+2];
                    t[2*j+1] = ((r[3*j] & r[3*j+1]) | (r[3*j] & r[3*j+2]) | (r[3*j+1] & r[3*j+2])) << 1;
                end
            end
            for (int k = 0; k < 32; k++) begin
                if (k >= 3 * g && k < n) t[k-g] = r[k];
            end
            r = t;
        end
        product = r[0] + r[1];
    end
endmodule

module wallace_mac #(
    parameter int ACC_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic             in_first,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf
);
    typedef enum logic {ACC, HOLD} state_t;
    state_t state_q, state_d;
    logic [31:0] s1_a_q, s1_b_q;
    logic s1_valid_q, s1_first_q, s1_last_q;
    logic [ACC_W-1:0] s2_prod_q, prod, acc_q, acc_d;
    logic s2_valid_q, s2_first_q, s2_last_q;
    logic ovf_q, ovf_d;
    logic [ACC_W:0] sum;
    logic accept;

    wallace u_mul (.product(prod), .a(s1_a_q), .b(s1_b_q));

    // Accumulate the S2 product; a first-marked pair starts from zero
    always_comb begin
        sum = {1'b0, s2_first_q ? {ACC_W{1'b0}} : acc_q} + {1'b0, s2_prod_q};
`ifdef WALLACE_MAC_SATURATE_EN
        acc_d = s2_valid_q ? (sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0]) : acc_q;
`else
        acc_d = s2_valid_q ? sum[ACC_W-1:0] : acc_q;
`endif
        ovf_d = s2_valid_q ? ((s2_first_q ? 1'b0 : ovf_q) | sum[ACC_W]) : ovf_q;
    end

    // Handshake and ACC/HOLD next state; input stalls while a last pair drains
    always_comb begin
        out_valid = state_q == HOLD;
        in_ready  = !rst && state_q == ACC && !(s1_valid_q && s1_last_q) && !(s2_valid_q && s2_last_q);
        accept    = in_valid && in_ready;
        state_d   = state_q == ACC ? ((s2_valid_q && s2_last_q) ? HOLD : ACC) : (out_ready ? ACC : HOLD);
    end

    // Pipeline, accumulator and state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            state_q    <= ACC;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_a_q     <= in_a;
                s1_b_q     <= in_b;
                s1_first_q <= in_first;
                s1_last_q  <= in_last;
            end
            s2_valid_q <= s1_valid_q;
            s2_prod_q  <= prod;
            s2_first_q <= s1_first_q;
            s2_last_q  <= s1_last_q;
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
            state_q    <= state_d;
        end
    end

    assign out_sum = acc_q;
    assign out_ovf = ovf_q;
endmodule

// File: tb/tb_wallace_mac.sv
// tb_wallace_mac: directed table-driven checks of wallace_mac (honours WALLACE_MAC_SATURATE_EN)
module tb_wallace_mac;
    logic clk = 1'b0;
    logic rst, in_valid, in_ready, in_first, in_last, out_valid, out_ready, out_ovf;
    logic [31:0] in_a, in_b;
    logic [63:0] out_sum;
    int n_chk = 0;
    int n_fail = 0;

    wallace_mac dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_first(in_first), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

`ifdef WALLACE_MAC_SATURATE_EN
    localparam logic [63:0] BIG = 64'hFFFF_FFFF_FFFF_FFFF;
`else
    localparam logic [63:0] BIG = 64'hFFFF_FFFC_0000_0002;
`endif

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        first;
        logic        last;
        logic [63:0] sum;
        logic        ovf;
    } vec_t;

    task automatic chk(input string name, input logic [66:0] act, input logic [66:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic f, input logic l, output int waits);
        bit ok;
        ok = 0;
        waits = 0;
        in_a = a; in_b = b; in_first = f; in_last = l; in_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (in_ready) begin
                ok = 1;
                @(posedge clk);
            end else begin
                waits++;
                @(negedge clk);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    task automatic wait_out(output int cyc);
        cyc = 1;
        while (!out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    vec_t v [10];
    int w, cyc;

    initial begin
        v[0] = '{32'd19, 32'd15, 1'b1, 1'b1, 64'd285, 1'b0};
        v[1] = '{32'd2, 32'd5, 1'b1, 1'b1, 64'd10, 1'b0};
        v[2] = '{32'd19, 32'd15, 1'b1, 1'b0, 64'd0, 1'b0};
        v[3] = '{32'd9943000, 32'd3302367, 1'b0, 1'b1, 64'd32835435081285, 1'b0};
        v[4] = '{32'd7, 32'd6, 1'b0, 1'b1, 64'd32835435081327, 1'b0};
        v[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 64'd0, 1'b0};
        v[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, BIG, 1'b1};
        v[7] = '{32'd0, 32'd12345, 1'b0, 1'b1, BIG, 1'b1};
        v[8] = '{32'd0, 32'd5, 1'b1, 1'b1, 64'd0, 1'b0};
        v[9] = '{32'd100000, 32'd100000, 1'b1, 1'b1, 64'd10000000000, 1'b0};

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_first = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_state", {in_ready, out_valid, out_ovf, out_sum}, {3'b000, 64'd0});
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", {66'd0, in_ready}, 67'd1);

        for (int i = 0; i < 10; i++) begin
            send(v[i].a, v[i].b, v[i].first, v[i].last, w);
            if (i == 3) chk("back_to_back_ready", w, 0);
            if (v[i].last) begin
                wait_out(cyc);
                chk($sformatf("latency_%0d", i), cyc, 3);
                chk($sformatf("sum_%0d", i), out_sum, v[i].sum);
                chk($sformatf("ovf_%0d", i), {66'd0, out_ovf}, {66'd0, v[i].ovf});
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    chk($sformatf("hold_%0d_%0d", i, k), {out_valid, in_ready, out_ovf, out_sum}, {2'b10, v[i].ovf, v[i].sum});
                end
                out_ready = 1'b1;
                @(negedge clk);
                out_ready = 1'b0;
                chk($sformatf("release_%0d", i), {65'd0, out_valid, in_ready}, 67'b01);
            end
        end

        send(32'd25983, 32'd641987, 1'b1, 1'b1, w);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (out_valid) cyc++;
        end
        chk("reset_discard", cyc, 0);
        send(32'd3, 32'd4, 1'b1, 1'b1, w);
        wait_out(cyc);
        chk("post_reset_latency", cyc, 3);
        chk("post_reset_sum", {out_ovf, out_sum}, {1'b0, 64'd12});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
